// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        REQ    = 2'd1,
        HOLD   = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer.sv
// Single-entry holding register for a fetched instruction and its address.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;

    // Clear wins over load so a flush always drops the word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= RESET_PC;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_control.sv
// Instruction fetch controller: SETTLE/REQ/HOLD sequencing, PC update strobe, redirect flush.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
//
// state  | meaning
// SETTLE | one idle cycle while the PC register absorbs a redirect
// REQ    | memory read of PC outstanding, waiting for mem_ready
// HOLD   | word buffered, waiting for decode to accept it
module fetch_control
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    output logic        PCWrite,
    output logic [31:0] PCNext,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        trap_misalign,
    output logic [31:0] trap_addr
);

    fetch_state_e state_q, state_d;
    logic         pcwrite_q, pcwrite_d;
    logic [31:0]  pcnext_q, pcnext_d;
    logic         buf_load, buf_clear;
    logic         misaligned_hold;
    logic         take_redirect;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        trap_q;
    logic [31:0] trap_addr_q;

    assign misaligned_hold = redirect_valid && (redirect_target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!reset) begin
            trap_q      <= 1'b0;
            trap_addr_q <= '0;
        end else begin
            trap_q <= misaligned_hold;
            if (misaligned_hold) begin
                trap_addr_q <= redirect_target;
            end
        end
    end

    assign trap_misalign = trap_q;
    assign trap_addr     = trap_addr_q;
`else
    assign misaligned_hold = 1'b0;
    assign trap_misalign   = 1'b0;
    assign trap_addr       = '0;
`endif

    assign take_redirect = redirect_valid && !misaligned_hold;

    always_comb begin
        state_d   = state_q;
        pcwrite_d = 1'b0;
        pcnext_d  = pcnext_q;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        if (take_redirect) begin
            pcwrite_d = 1'b1;
            pcnext_d  = redirect_target & ~32'h3;
            buf_clear = 1'b1;
            state_d   = SETTLE;
        end else if (!misaligned_hold) begin
            case (state_q)
                SETTLE: state_d = REQ;
                REQ: begin
                    if (mem_ready) begin
                        buf_load  = 1'b1;
                        pcwrite_d = 1'b1;
                        pcnext_d  = PC + PC_STEP;
                        state_d   = HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        buf_clear = 1'b1;
                        state_d   = REQ;
                    end
                end
                default: state_d = SETTLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= SETTLE;
            pcwrite_q <= 1'b0;
            pcnext_q  <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pcwrite_q <= pcwrite_d;
            pcnext_q  <= pcnext_d;
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk     (clk),
        .reset   (reset),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .instr_i (mem_rdata),
        .pc_i    (PC),
        .valid_o (instr_valid),
        .instr_o (instr_out),
        .pc_o    (instr_pc)
    );

    // The request is gated by reset so it is low during the reset cycle itself.
    assign mem_req  = reset && (state_q == REQ);
    assign mem_addr = PC;
    assign PCWrite  = pcwrite_q;
    assign PCNext   = pcnext_q;

endmodule
